change_code: RTL and testbench

Registered two's-complement (U2) to sign-magnitude (ZM) code converter. It is an execution unit of the APB-attached ALU: the bus wrapper presents one operand and receives the converted result plus an error flag. The error flag is raised for the single U2 value that has no sign-magnitude representation.

---
 rtl/change_code_pkg.sv | 21 ++
 rtl/change_code_core.sv | 42 ++++
 rtl/change_code.sv | 61 ++++++
 tb/tb_change_code.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/change_code_pkg.sv
// change_code_pkg
// Shared definitions for the two's-complement to sign-magnitude converter.
//   MAX_BITS     : widest operand the helper function can describe
//   wide_word_t  : container word wide enough for any supported BITS
//   min_value()  : most negative two's-complement code for a given width
package change_code_pkg;

  localparam int MAX_BITS = 64;

  typedef logic [MAX_BITS-1:0] wide_word_t;

  // Most negative two's-complement value {1, 0...0} for a 'bits'-wide word.
  // This is the one code with no sign-magnitude equivalent.
  function automatic wide_word_t min_value(input int bits);
    wide_word_t v;
    v = {MAX_BITS{1'b0}};
    v[bits-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/change_code_core.sv
// changecode_core
// Purely combinational two's-complement to sign-magnitude conversion.
// Ports:
//   i_argA  [BITS] operand in two's complement
//   result  [BITS] sign-magnitude result (MSB sign, low BITS-1 magnitude)
//   err     [1]    operand is the most negative value, not representable
module changecode_core
  import change_code_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] i_argA,
  output logic [BITS-1:0] result,
  output logic            err
);

  localparam type word_t = logic [BITS-1:0];
  localparam word_t MIN  = word_t'(min_value(BITS));
  localparam word_t ONE  = word_t'(1);

  word_t negated_s;

  // Magnitude of a negative operand, modulo 2^BITS.
  assign negated_s = ~i_argA + ONE;

  // Select conversion by operand sign; MIN is flagged and forced to zero.
  always_comb begin
    result = {BITS{1'b0}};
    err    = 1'b0;
    if (!i_argA[BITS-1]) begin
      result = i_argA;
      err    = 1'b0;
    end else if (i_argA == MIN) begin
      result = {BITS{1'b0}};
      err    = 1'b1;
    end else begin
      result = {1'b1, negated_s[BITS-2:0]};
      err    = 1'b0;
    end
  end

endmodule

// File: rtl/change_code.sv
// change_code
// Registered two's-complement to sign-magnitude converter, one-cycle latency.
// Ports:
//   i_clk     [1]    rising-edge clock
//   i_rst_n   [1]    synchronous active-low reset
//   i_valid   [1]    i_argA holds a new operand this cycle
//   i_argA    [BITS] operand in two's complement
//   o_valid   [1]    o_result/error were updated by the last edge
//   o_result  [BITS] sign-magnitude result, held while o_valid is low
//   error     [1]    operand not representable, held while o_valid is low
module change_code
  import change_code_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [BITS-1:0] i_argA,
  output logic            o_valid,
  output logic [BITS-1:0] o_result,
  output logic            error
);

  logic [BITS-1:0] core_result_s;
  logic            core_err_s;
  logic            valid_r;
  logic [BITS-1:0] result_r;
  logic            error_r;

  changecode_core #(
    .BITS (BITS)
  ) u_core (
    .i_argA (i_argA),
    .result (core_result_s),
    .err    (core_err_s)
  );

  // Output registers: capture on valid, hold otherwise; reset wins over valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_r  <= 1'b0;
      result_r <= {BITS{1'b0}};
      error_r  <= 1'b0;
    end else begin
      valid_r <= i_valid;
      if (i_valid) begin
        result_r <= core_result_s;
        error_r  <= core_err_s;
      end else begin
        result_r <= result_r;
        error_r  <= error_r;
      end
    end
  end

  assign o_valid  = valid_r;
  assign o_result = result_r;
  assign error    = error_r;

endmodule

// File: tb/tb_change_code.sv
// tb_change_code
// Directed, table-driven bench for change_code at BITS = 4 and BITS = 8.
module tb_change_code;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [3:0] arg4;
  logic [7:0] arg8;
  logic       ov4, ov8;
  logic [3:0] res4;
  logic [7:0] res8;
  logic       err4, err8;

  int n_cmp = 0;
  int n_bad = 0;

  change_code #(.BITS(4)) dut4 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid),
    .i_argA   (arg4),
    .o_valid  (ov4),
    .o_result (res4),
    .error    (err4)
  );

  change_code #(.BITS(8)) dut8 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid),
    .i_argA   (arg8),
    .o_valid  (ov8),
    .o_result (res8),
    .error    (err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] exp_res;
    logic       exp_err;
  } vec4_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] exp_res;
    logic       exp_err;
  } vec8_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent arithmetic model: value-based, not bitwise.
  function automatic void model(input int bits, input int a,
                                output int res, output int err);
    int half;
    half = 1 << (bits - 1);
    if (a < half) begin
      res = a; err = 0;
    end else if (a == half) begin
      res = 0; err = 1;
    end else begin
      res = half + ((1 << bits) - a); err = 0;
    end
  endfunction

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic step4(input logic v, input logic [3:0] a);
    @(negedge clk);
    valid = v;
    arg4  = a;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic v, input logic [7:0] a);
    @(negedge clk);
    valid = v;
    arg8  = a;
    @(posedge clk);
    #1;
  endtask

  vec4_t tab4[8];
  vec8_t tab8[5];
  int    er, ee;

  initial begin
    tab4[0] = '{4'b0001, 4'b0001, 1'b0};
    tab4[1] = '{4'b1000, 4'b0000, 1'b1};
    tab4[2] = '{4'b1001, 4'b1111, 1'b0};
    tab4[3] = '{4'b1101, 4'b1011, 1'b0};
    tab4[4] = '{4'b1111, 4'b1001, 1'b0};
    tab4[5] = '{4'b0111, 4'b0111, 1'b0};
    tab4[6] = '{4'b0000, 4'b0000, 1'b0};
    tab4[7] = '{4'b1110, 4'b1010, 1'b0};

    tab8[0] = '{8'b10000000, 8'b00000000, 1'b0 | 1'b1};
    tab8[1] = '{8'b11111111, 8'b10000001, 1'b0};
    tab8[2] = '{8'b01111111, 8'b01111111, 1'b0};
    tab8[3] = '{8'b10000001, 8'b11111111, 1'b0};
    tab8[4] = '{8'b11001000, 8'b10111000, 1'b0};

    // Reset held two cycles with a live operand presented.
    rst_n = 1'b0;
    valid = 1'b1;
    arg4  = 4'b1111;
    arg8  = 8'b11111111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ovalid4", int'(ov4), 0);
    check("rst_result4", int'(res4), 0);
    check("rst_error4",  int'(err4), 0);
    check("rst_ovalid8", int'(ov8), 0);
    check("rst_result8", int'(res8), 0);

    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table vectors at BITS = 4.
    for (int i = 0; i < 8; i++) begin
      step4(1'b1, tab4[i].a);
      check($sformatf("tab4_valid[%0d]", i), int'(ov4), 1);
      check($sformatf("tab4_res[%0d]", i),   int'(res4), int'(tab4[i].exp_res));
      check($sformatf("tab4_err[%0d]", i),   int'(err4), int'(tab4[i].exp_err));
    end

    // Hold: 1101 -> 1011 registered, then idle with a changed operand.
    step4(1'b1, 4'b1101);
    check("hold_pre_res", int'(res4), 4'b1011);
    step4(1'b0, 4'b0111);
    check("hold_valid", int'(ov4), 0);
    check("hold_res",   int'(res4), 4'b1011);
    check("hold_err",   int'(err4), 0);

    // Hold of the error flag after MIN.
    step4(1'b1, 4'b1000);
    step4(1'b0, 4'b0011);
    check("hold_err_flag", int'(err4), 1);
    check("hold_err_res",  int'(res4), 0);

    // Reset mid-stream discards the operand, then first edge resumes.
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b1;
    arg4  = 4'b0011;
    @(posedge clk);
    #1;
    check("midrst_valid", int'(ov4), 0);
    check("midrst_res",   int'(res4), 0);
    check("midrst_err",   int'(err4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume_valid", int'(ov4), 1);
    check("resume_res",   int'(res4), 4'b0011);

    // Exhaustive BITS = 4 sweep against the arithmetic model.
    for (int a = 0; a < 16; a++) begin
      step4(1'b1, 4'(a));
      model(4, a, er, ee);
      check($sformatf("sweep4_res[%0d]", a), int'(res4), er);
      check($sformatf("sweep4_err[%0d]", a), int'(err4), ee);
      check($sformatf("sweep4_valid[%0d]", a), int'(ov4), 1);
    end

    // BITS = 8 table vectors.
    for (int i = 0; i < 5; i++) begin
      step8(1'b1, tab8[i].a);
      check($sformatf("tab8_valid[%0d]", i), int'(ov8), 1);
      check($sformatf("tab8_res[%0d]", i),   int'(res8), int'(tab8[i].exp_res));
      check($sformatf("tab8_err[%0d]", i),   int'(err8), int'(tab8[i].exp_err));
    end

    // Exhaustive BITS = 8 sweep against the model.
    for (int a = 0; a < 256; a++) begin
      step8(1'b1, 8'(a));
      model(8, a, er, ee);
      check($sformatf("sweep8_res[%0d]", a), int'(res8), er);
      check($sformatf("sweep8_err[%0d]", a), int'(err8), ee);
    end

    step8(1'b0, 8'b00000000);
    check("idle8_valid", int'(ov8), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
